// File: rtl/tff_count_sequencer.sv
// Toggle-register count sequencer: up/down, one-shot/continuous, count <= count ^ t_vec.
// Optional PAUSED state and pause input enabled by defining TFF_SEQ_PAUSE_EN.
module tff_count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             s_reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             mode,
`ifdef TFF_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

`ifdef TFF_SEQ_PAUSE_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, PAUSED} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t           r_state, w_next_state;
  logic [WIDTH-1:0] r_count, r_limit;
  logic             r_dir, r_mode;
  logic [WIDTH-1:0] w_next_count, w_up_mask, w_dn_mask, w_step;
  logic [WIDTH-1:0] w_start_val, w_reload_val, w_end_val;
  logic             w_term, w_load, w_wrap;

  // Increment/decrement toggle masks built from a running carry/borrow chain
  always_comb begin
    w_up_mask    = '0;
    w_dn_mask    = '0;
    w_up_mask[0] = 1'b1;
    w_dn_mask[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_up_mask[i] = w_up_mask[i-1] & r_count[i-1];
      w_dn_mask[i] = w_dn_mask[i-1] & ~r_count[i-1];
    end
  end

  assign w_step       = r_dir ? w_up_mask : w_dn_mask;
  assign w_start_val  = dir ? '0 : limit;
  assign w_reload_val = r_dir ? '0 : r_limit;
  assign w_end_val    = r_dir ? r_limit : '0;
  assign w_term       = (r_count == w_end_val);

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_load       = 1'b0;
    w_wrap       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_next_state = RUN;
          w_next_count = w_start_val;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          w_next_state = IDLE;
`ifdef TFF_SEQ_PAUSE_EN
        end else if (pause) begin
          w_next_state = PAUSED;
`endif
        end else if (w_term) begin
          if (r_mode) begin
            w_next_count = w_reload_val;
            w_wrap       = 1'b1;
          end else begin
            w_next_state = DONE;
          end
        end else begin
          w_next_count = r_count ^ w_step;
        end
      end
`ifdef TFF_SEQ_PAUSE_EN
      PAUSED: begin
        if (stop)        w_next_state = IDLE;
        else if (!pause) w_next_state = RUN;
      end
`endif
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    // Reset is expressed as a toggle back to zero so count only ever updates via t_vec
    if (s_reset) begin
      w_next_state = IDLE;
      w_next_count = '0;
      w_load       = 1'b0;
      w_wrap       = 1'b0;
    end
  end

  assign t_vec = r_count ^ w_next_count;

  always_ff @(posedge clk) begin
    r_state <= w_next_state;
    r_count <= r_count ^ t_vec;
    if (s_reset) begin
      r_dir   <= 1'b0;
      r_mode  <= 1'b0;
      r_limit <= '0;
    end else if (w_load) begin
      r_dir   <= dir;
      r_mode  <= mode;
      r_limit <= limit;
    end
  end

  assign count = r_count;
`ifdef TFF_SEQ_PAUSE_EN
  assign busy  = (r_state == RUN) || (r_state == PAUSED);
`else
  assign busy  = (r_state == RUN);
`endif
  assign done  = (r_state == DONE);
  assign wrap  = w_wrap;

endmodule

// File: doc/tff_count_sequencer.md
TFF_COUNT_SEQUENCER -- requirements
Module: tff_count_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, counter and limit width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port s_reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin a count sequence.
REQ-005 The block SHALL have port stop, input, 1 bit: abort the sequence.
REQ-006 The block SHALL have port dir, input, 1 bit: 1 = up, 0 = down; sampled on accepted start only.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = one-shot, 1 = continuous; sampled on accepted start only.
REQ-008 The block SHALL have port limit, input, WIDTH bits: terminal value; sampled on accepted start only.
REQ-009 The block SHALL have port count, output, WIDTH bits: current toggle-register value.
REQ-010 The block SHALL have port t_vec, output, WIDTH bits: combinational toggle mask, equal to count XOR next count.
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN (and PAUSED when REQ-025 is enabled).
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse on one-shot completion.
REQ-013 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on continuous-mode reload.

Function
REQ-014 The block SHALL use exactly three FSM states (IDLE, RUN, DONE) and SHALL update count only as count <= count XOR t_vec.
REQ-015 In IDLE, start=1 with stop=0 SHALL latch dir, mode and limit, and load count with the start value in the same edge (0 if up, limit if down), with next state RUN.
REQ-016 In RUN, a non-terminal cycle SHALL step count by 1 in the latched direction.
  - Up: t_vec[0]=1, t_vec[i]=AND of count[i-1:0].
  - Down: t_vec[0]=1, t_vec[i]=AND of ~count[i-1:0].
REQ-017 A RUN cycle is terminal when count equals the end value (latched limit if up, 0 if down).
  - One-shot terminal: count is held (t_vec=0) and next state is DONE.
  - Continuous terminal: count is reloaded to the start value, wrap=1 for that one cycle, and state stays RUN.
REQ-018 DONE SHALL last exactly one cycle with done=1, busy=0, count held; next state is IDLE.
REQ-019 stop=1 in RUN SHALL force next state IDLE with count held and no done or wrap pulse; stop SHALL override terminal detection in the same cycle.
REQ-020 start SHALL be ignored outside IDLE; start and stop together in IDLE SHALL leave the block in IDLE.
REQ-021 limit=0 SHALL be legal: the first RUN cycle is terminal in either direction.
REQ-022 Latency SHALL be as follows: start accepted at edge N gives busy=1 after edge N; one-shot up with limit L gives done=1 in the cycle after edge N+L+1.

Reset
REQ-023 s_reset=1 at a clock edge SHALL set state IDLE, count=0, the latched dir/mode/limit to 0, and done=wrap=busy=0; t_vec SHALL then read 0.
REQ-024 s_reset SHALL take priority over start, stop and any in-progress sequence, including mid-RUN and in DONE.

Configuration
REQ-025 With macro TFF_SEQ_PAUSE_EN defined, the block SHALL add input port pause (1 bit) and a fourth state, PAUSED.
  - RUN with pause=1: next state PAUSED, count held.
  - PAUSED with pause=0: next state RUN.
  - stop in PAUSED: next state IDLE.
  - busy=1 in PAUSED; t_vec=0 in PAUSED.
  - Without TFF_SEQ_PAUSE_EN, the block SHALL have no pause port and no PAUSED state.

Verification
REQ-026 Reset: assert s_reset during RUN with count=5 -> after the next edge, count=0, busy=0, and t_vec=0.
REQ-027 One-shot up: WIDTH=4, limit=3, dir=1, mode=0, start pulse -> count 0,1,2,3,3 on successive cycles, done=1 exactly once, then IDLE with count=3.
REQ-028 Continuous down: limit=2, dir=0, mode=1 -> count 2,1,0,2,1,0, wrap=1 on each 0 cycle, done never asserted.
REQ-029 Stop versus terminal: one-shot up with limit=4 and stop=1 in the count=4 cycle -> IDLE, count=4, done=0.
REQ-030 Carry and no re-trigger: WIDTH=4 up with count=7 -> t_vec=4'b1111 and count=8 next; start pulses during RUN are ignored; limit=0 start gives done one cycle after RUN entry.
REQ-031 Pause (TFF_SEQ_PAUSE_EN defined): pause=1 for 3 cycles at count=2 -> count holds at 2 with busy=1, then resumes at 3.
